// File: rtl/camera_downsampler_if.sv
// camera_downsampler_if
//   Bundles the OV7670 capture bus and the frame-buffer write bus seen by
//   camera_downsampler.
//   Camera side : CAM_DATA[7:0], CAM_HREF, CAM_VSYNC
//   Buffer side : PIXEL_OUT[7:0] (RGB332), W_EN, WRITE_ADDR[ADDR_W-1:0],
//                 FRAME_DONE
//   Modports:
//     slave  - the downsampler: consumes camera signals, drives buffer signals
//     master - the environment: drives camera signals, observes buffer signals
interface camera_downsampler_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        CAM_DATA;
  logic              CAM_HREF;
  logic              CAM_VSYNC;
  logic [7:0]        PIXEL_OUT;
  logic              W_EN;
  logic [ADDR_W-1:0] WRITE_ADDR;
  logic              FRAME_DONE;

  modport slave (
    input  CAM_DATA, CAM_HREF, CAM_VSYNC,
    output PIXEL_OUT, W_EN, WRITE_ADDR, FRAME_DONE
  );

  modport master (
    output CAM_DATA, CAM_HREF, CAM_VSYNC,
    input  PIXEL_OUT, W_EN, WRITE_ADDR, FRAME_DONE
  );
endinterface

// File: rtl/camera_downsampler.sv
// camera_downsampler
//   Captures the OV7670 8-bit parallel bus (RGB565, high byte first, framed by
//   HREF/VSYNC), packs each pixel to RGB332 and writes it into a
//   SCREEN_WIDTH x SCREEN_HEIGHT frame buffer at address Y*SCREEN_WIDTH + X.
//   Pixels beyond the stored width/height are dropped (X and Y saturate).
//   A frame starts on a VSYNC falling edge; a VSYNC rising edge ends it and
//   pulses FRAME_DONE if at least one line carried a pixel.
//
//   Ports:
//     CLK   - camera pixel clock (PCLK), rising edge
//     RESET - synchronous, active-high; returns to waiting for a frame start
//     bus   - camera_downsampler_if.slave (camera bus in, buffer write bus out)
//
//   Build option:
//     DOWNSAMPLER_TEST_PATTERN_EN - when defined, PIXEL_OUT ignores the camera
//     data and shows horizontal red/green/blue bars by line; timing,
//     addressing and W_EN are unchanged.
module camera_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  camera_downsampler_if.slave   bus
);

  localparam int X_W = $clog2(SCREEN_WIDTH + 1);
  localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);

  localparam logic [X_W-1:0]    X_MAX    = X_W'(SCREEN_WIDTH);
  localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(SCREEN_WIDTH);

`ifdef DOWNSAMPLER_TEST_PATTERN_EN
  localparam logic [Y_W-1:0] BAR_GREEN = Y_W'(48);
  localparam logic [Y_W-1:0] BAR_BLUE  = Y_W'(96);
`endif

  localparam logic [1:0] WAIT_FRAME = 2'd0;
  localparam logic [1:0] IDLE_LINE  = 2'd1;
  localparam logic [1:0] BYTE_LO    = 2'd2;
  localparam logic [1:0] BYTE_HI    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              href_q, href_d;
  logic              vsync_q, vsync_d;
  // Only the high-byte bits that survive RGB332 packing are kept.
  logic [5:0]        hi_q, hi_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  // Running Y*SCREEN_WIDTH, so the write address needs no multiplier.
  logic [ADDR_W-1:0] base_q, base_d;
  logic              line_had_pixel_q, line_had_pixel_d;
  logic              frame_had_line_q, frame_had_line_d;
  logic [7:0]        pixel_q, pixel_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;

  logic vsync_rise, vsync_fall, href_fall;
  logic [7:0] pixel_new;

  assign vsync_rise = bus.CAM_VSYNC & ~vsync_q;
  assign vsync_fall = ~bus.CAM_VSYNC & vsync_q;
  assign href_fall  = ~bus.CAM_HREF & href_q;

`ifdef DOWNSAMPLER_TEST_PATTERN_EN
  always_comb begin
    if (y_q < BAR_GREEN)     pixel_new = 8'hE0;
    else if (y_q < BAR_BLUE) pixel_new = 8'h1C;
    else                     pixel_new = 8'h03;
  end
`else
  assign pixel_new = {hi_q, bus.CAM_DATA[4:3]};
`endif

  always_comb begin
    state_d          = state_q;
    href_d           = bus.CAM_HREF;
    vsync_d          = bus.CAM_VSYNC;
    hi_d             = hi_q;
    x_d              = x_q;
    y_d              = y_q;
    base_d           = base_q;
    line_had_pixel_d = line_had_pixel_q;
    frame_had_line_d = frame_had_line_q;
    pixel_d          = pixel_q;
    w_en_d           = 1'b0;
    addr_d           = addr_q;
    frame_done_d     = 1'b0;

    if (state_q == WAIT_FRAME) begin
      if (vsync_fall) begin
        state_d          = IDLE_LINE;
        x_d              = '0;
        y_d              = '0;
        base_d           = '0;
        line_had_pixel_d = 1'b0;
        frame_had_line_d = 1'b0;
      end
    end else if (vsync_rise) begin
      // End of frame wins over any byte or line event in the same cycle,
      // which also drops a half-captured pixel.
      state_d          = WAIT_FRAME;
      frame_done_d     = frame_had_line_q;
      line_had_pixel_d = 1'b0;
      frame_had_line_d = 1'b0;
    end else begin
      case (state_q)
        IDLE_LINE: begin
          if (bus.CAM_HREF) begin
            hi_d    = {bus.CAM_DATA[7:5], bus.CAM_DATA[2:0]};
            state_d = BYTE_LO;
          end
        end
        BYTE_LO: begin
          if (bus.CAM_HREF) begin
            pixel_d          = pixel_new;
            addr_d           = base_q + ADDR_W'(x_q);
            w_en_d           = (x_q < X_MAX) && (y_q < Y_MAX);
            x_d              = (x_q < X_MAX) ? x_q + X_W'(1) : x_q;
            line_had_pixel_d = 1'b1;
            state_d          = BYTE_HI;
          end else begin
            state_d = IDLE_LINE;
          end
        end
        BYTE_HI: begin
          if (bus.CAM_HREF) begin
            hi_d    = {bus.CAM_DATA[7:5], bus.CAM_DATA[2:0]};
            state_d = BYTE_LO;
          end else begin
            state_d = IDLE_LINE;
          end
        end
        default: ;
      endcase

      // HREF is low on a falling edge, so this never coincides with a
      // pixel completing above.
      if (href_fall) begin
        line_had_pixel_d = 1'b0;
        if (line_had_pixel_q) begin
          x_d              = '0;
          frame_had_line_d = 1'b1;
          if (y_q < Y_MAX) begin
            y_d    = y_q + Y_W'(1);
            base_d = base_q + LINE_INC;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= WAIT_FRAME;
      href_q           <= 1'b0;
      vsync_q          <= 1'b0;
      hi_q             <= '0;
      x_q              <= '0;
      y_q              <= '0;
      base_q           <= '0;
      line_had_pixel_q <= 1'b0;
      frame_had_line_q <= 1'b0;
      pixel_q          <= '0;
      w_en_q           <= 1'b0;
      addr_q           <= '0;
      frame_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      href_q           <= href_d;
      vsync_q          <= vsync_d;
      hi_q             <= hi_d;
      x_q              <= x_d;
      y_q              <= y_d;
      base_q           <= base_d;
      line_had_pixel_q <= line_had_pixel_d;
      frame_had_line_q <= frame_had_line_d;
      pixel_q          <= pixel_d;
      w_en_q           <= w_en_d;
      addr_q           <= addr_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign bus.PIXEL_OUT  = pixel_q;
  assign bus.W_EN       = w_en_q;
  assign bus.WRITE_ADDR = addr_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: doc/camera_downsampler.md
Name: camera_downsampler

Overview:
- Upstream neighbour of the colour-detection image processor.
- Samples the OV7670 8-bit parallel bus (RGB565, two bytes per pixel, HREF/VSYNC framing) and packs each pixel into RGB332.
- Writes each pixel into the 176x144 frame-buffer M9K with a linear write address and write enable.
- The VGA side reads that buffer and feeds the image processor.

Parameters:
- SCREEN_WIDTH, 176: pixels per line stored; extra pixels on a line are dropped.
- SCREEN_HEIGHT, 144: lines per frame stored; extra lines are dropped.
- ADDR_W, 15: write address width; must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT.

Ports:
- CLK  in  1  camera pixel clock (PCLK); all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CAM_DATA  in  8  camera data byte.
- CAM_HREF  in  1  high while line bytes are valid.
- CAM_VSYNC  in  1  high during vertical blanking; frame starts on falling edge.
- PIXEL_OUT  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- W_EN  out  1  frame-buffer write enable; one-cycle pulse per stored pixel.
- WRITE_ADDR  out  ADDR_W  linear address = Y*SCREEN_WIDTH + X.
- FRAME_DONE  out  1  one-cycle pulse on VSYNC rising edge after a valid frame.

Behaviour:
- Edge detect: CAM_HREF and CAM_VSYNC registered once per cycle; rise/fall are decoded against the registered copy.
- Reset values: PIXEL_OUT=0, W_EN=0, WRITE_ADDR=0, FRAME_DONE=0, X=0, Y=0, byte-phase=HI, state=WAIT_FRAME, line_had_pixel=0, frame_had_line=0.
- State WAIT_FRAME: ignore all data; on VSYNC falling edge -> IDLE_LINE, X=0, Y=0.
- State IDLE_LINE: on cycle with CAM_HREF=1, sample CAM_DATA as high byte -> BYTE_LO.
- State BYTE_LO: CAM_HREF=1 -> sample low byte, form pixel, -> BYTE_HI. CAM_HREF=0 -> discard the half pixel, -> IDLE_LINE.
- State BYTE_HI: CAM_HREF=1 -> sample high byte -> BYTE_LO. CAM_HREF=0 -> IDLE_LINE.
- Packing: hi=CAM_DATA on high cycle, lo on low cycle. PIXEL_OUT = {hi[7:5], hi[2:0], lo[4:3]}.
- Latency: PIXEL_OUT, WRITE_ADDR and W_EN are registered together, valid the cycle after the low byte is sampled.
- W_EN=1 only if X<SCREEN_WIDTH and Y<SCREEN_HEIGHT. X increments after every completed pixel and saturates at SCREEN_WIDTH; no wrap.
- End of line: on HREF falling edge with line_had_pixel=1, Y increments (saturates at SCREEN_HEIGHT), X=0, frame_had_line=1. HREF pulses with no completed pixel do not advance Y.
- End of frame: VSYNC rising edge in any line state -> FRAME_DONE=1 for one cycle if frame_had_line=1, then state WAIT_FRAME.
- VSYNC rising while HREF is high: the pending half pixel is discarded and no Y increment occurs.
- Reset mid-frame: the block re-enters WAIT_FRAME and writes nothing until the next VSYNC fall, so a partial frame is never written.
- Reset has priority over all other events in the same cycle.

Optional Feature:
- Macro DOWNSAMPLER_TEST_PATTERN_EN.
- Defined: camera data is ignored for PIXEL_OUT, which becomes horizontal bars by Y. Y<48 -> 8'hE0 (red), 48<=Y<96 -> 8'h1C (green), Y>=96 -> 8'h03 (blue). Timing, addressing and W_EN are unchanged. Used to verify the image processor and VGA path.
- Undefined: normal packing; no pattern logic synthesised.

Test Plan:
- Reset then VSYNC fall, one HREF line of 4 bytes F8,00,07,E0 -> two W_EN pulses. PIXEL_OUT=E0 @ addr 0, then 1C @ addr 1; X=2.
- Full frame of 144 lines x 176 pixels, then VSYNC rise -> exactly 25344 W_EN pulses, last WRITE_ADDR=25343, one FRAME_DONE pulse.
- Line with 180 pixels -> 176 writes; writes at X=176..179 suppressed; next line starts at addr 176.
- HREF drops after 3 bytes -> 1 write, half pixel discarded; next line's first pixel at Y*176.
- RESET asserted mid-line on line 10 -> no W_EN until next VSYNC fall; then first write at addr 0; FRAME_DONE not pulsed for the aborted frame.
- With DOWNSAMPLER_TEST_PATTERN_EN and any CAM_DATA -> PIXEL_OUT=E0 at Y=47, 1C at Y=48, 03 at Y=96.
